// File: rtl/matrix_capture_pkg.sv
// matrix_capture_pkg
//   Shared constants, types and helpers for the HUB75 capture block.
//   Geometry: COLS pixels per line, ROW_BITS row address bits, PLANES brightness
//   planes per row (sent MSB plane first). px_beat_t is one output beat and
//   drain_state_t is the encoding of the line drain FSM.
package matrix_capture_pkg;

  localparam int COLS     = 64;
  localparam int ROW_BITS = 4;
  localparam int PLANES   = 6;

  localparam int COL_W    = 6;   // column index width (px_col)
  localparam int CNT_W    = 7;   // fill counter must be able to hold COLS itself
  localparam int PLANE_W  = 3;
  localparam int RGB_W    = 6;

  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    DRAIN = 1'b1
  } drain_state_t;

  typedef struct packed {
    logic [ROW_BITS-1:0] row;
    logic [COL_W-1:0]    col;
    logic [PLANE_W-1:0]  plane;
    logic [RGB_W-1:0]    rgb;
    logic                first;
  } px_beat_t;

  // Plane of a repeated row: one below the previous plane, wrapping 0 -> PLANES-1.
  function automatic logic [PLANE_W-1:0] next_plane(input logic [PLANE_W-1:0] prev);
    if (prev == {PLANE_W{1'b0}}) begin
      return PLANE_W'(PLANES - 1);
    end else begin
      return prev - PLANE_W'(1);
    end
  endfunction

endpackage

// File: rtl/matrix_line_buffer.sv
// matrix_line_buffer
//   Ping-pong line storage: two banks of COLS x 6-bit pixels. One bank is
//   filled from the panel side while the other is read by the drain side;
//   'swap' exchanges the roles on the next clock edge.
// Ports
//   clk, rst_n : clock and asynchronous active-low reset (bank select only)
//   wr_en, wr_addr, wr_data : write into the fill bank
//   swap    : exchange fill and drain banks
//   rd_addr : drain bank read address; rd_data combinational read data
module matrix_line_buffer
  import matrix_capture_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             wr_en,
  input  logic [COL_W-1:0] wr_addr,
  input  logic [RGB_W-1:0] wr_data,
  input  logic             swap,
  input  logic [COL_W-1:0] rd_addr,
  output logic [RGB_W-1:0] rd_data
);

  logic [RGB_W-1:0] mem_q [2][COLS];
  logic             fill_sel_q;
  logic             fill_sel_d;

  // Next bank select.
  always_comb begin
    if (swap) begin
      fill_sel_d = ~fill_sel_q;
    end else begin
      fill_sel_d = fill_sel_q;
    end
  end

  // Bank select register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fill_sel_q <= 1'b0;
    end else begin
      fill_sel_q <= fill_sel_d;
    end
  end

  // Pixel storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[fill_sel_q][wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem_q[~fill_sel_q][rd_addr];

endmodule

// File: rtl/matrix_scan_capture.sv
// matrix_scan_capture
//   Receiver for the HUB75 panel bus. All hub_* pins are oversampled through a
//   SYNC_STAGES synchroniser, edges are detected on the synchronised copies,
//   each latched row is rebuilt in a ping-pong line buffer and streamed out as
//   (row, col, plane, rgb) beats with a valid/ready handshake.
// Ports
//   clk_in, reset        : system clock, asynchronous active-low reset
//   hub_clk/lat/oe/addr/rgb : panel bus inputs
//   px_valid/ready, px_row/col/plane/rgb/first : output beat stream
//   col_err   : pulse, line latched with a column count other than COLS
//   line_drop : pulse, good line discarded because the drain side is busy
//   oe_width, oe_valid : OE high time after the last latch (macro OE_MEASURE_EN;
//                        tied 0 when the macro is undefined)
module matrix_scan_capture
  import matrix_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic                clk_in,
  input  logic                reset,
  input  logic                hub_clk,
  input  logic                hub_lat,
  input  logic                hub_oe,
  input  logic [ROW_BITS-1:0] hub_addr,
  input  logic [5:0]          hub_rgb,
  output logic                px_valid,
  input  logic                px_ready,
  output logic [ROW_BITS-1:0] px_row,
  output logic [5:0]          px_col,
  output logic [2:0]          px_plane,
  output logic [5:0]          px_rgb,
  output logic                px_first,
  output logic                col_err,
  output logic                line_drop,
  output logic [7:0]          oe_width,
  output logic                oe_valid
);

  localparam int SW = 3 + ROW_BITS + RGB_W;  // {oe, lat, clk, addr, rgb}

  logic [SW-1:0] sync_q [SYNC_STAGES];
  logic [SW-1:0] sync_d [SYNC_STAGES];
  logic [2:0]    prev_q;  // previous synchronised {oe, lat, clk}
  logic [SW-1:0] sync_w;

  logic                s_clk, s_lat, s_oe;
  logic [ROW_BITS-1:0] s_addr;
  logic [RGB_W-1:0]    s_rgb;
  logic                clk_rise, lat_rise;

  // Synchroniser chain next values.
  always_comb begin
    sync_d[0] = {hub_oe, hub_lat, hub_clk, hub_addr, hub_rgb};
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchroniser and edge-detect history registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= {SW{1'b0}};
      end
      prev_q <= 3'b000;
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
      prev_q <= {s_oe, s_lat, s_clk};
    end
  end

  assign sync_w   = sync_q[SYNC_STAGES-1];
  assign s_rgb    = sync_w[RGB_W-1:0];
  assign s_addr   = sync_w[RGB_W +: ROW_BITS];
  assign s_clk    = sync_w[RGB_W + ROW_BITS];
  assign s_lat    = sync_w[RGB_W + ROW_BITS + 1];
  assign s_oe     = sync_w[RGB_W + ROW_BITS + 2];
  assign clk_rise = s_clk & ~prev_q[0];
  assign lat_rise = s_lat & ~prev_q[1];

  // ---------------- fill side ----------------
  logic [CNT_W-1:0]    col_cnt_q, col_cnt_d;
  logic                overrun_q, overrun_d;
  logic [ROW_BITS-1:0] last_row_q, last_row_d;
  logic [PLANE_W-1:0]  plane_q, plane_d;
  logic [ROW_BITS-1:0] line_row_q, line_row_d;
  logic [PLANE_W-1:0]  line_plane_q, line_plane_d;
  logic                commit_q, commit_d;
  logic                col_err_q, col_err_d;
  logic                line_drop_q, line_drop_d;
  logic                wr_en, swap;
  logic [CNT_W-1:0]    cnt_after;
  logic                over_after;
  logic [PLANE_W-1:0]  new_plane;

  drain_state_t        state_q;
  px_beat_t            beat_q;
  logic [COL_W-1:0]    rd_addr;
  logic [RGB_W-1:0]    rd_data;

  // Pixel capture, latch evaluation and plane tracking. A pixel edge in the
  // same sample as the latch edge is counted before the latch is judged.
  always_comb begin
    col_cnt_d    = col_cnt_q;
    overrun_d    = overrun_q;
    last_row_d   = last_row_q;
    plane_d      = plane_q;
    line_row_d   = line_row_q;
    line_plane_d = line_plane_q;
    commit_d     = 1'b0;
    col_err_d    = 1'b0;
    line_drop_d  = 1'b0;
    wr_en        = 1'b0;
    swap         = 1'b0;
    cnt_after    = col_cnt_q;
    over_after   = overrun_q;
    new_plane    = PLANE_W'(PLANES - 1);

    if (clk_rise) begin
      if (col_cnt_q < CNT_W'(COLS)) begin
        wr_en     = 1'b1;
        cnt_after = col_cnt_q + CNT_W'(1);
      end else begin
        over_after = 1'b1;
      end
    end else begin
      cnt_after = col_cnt_q;
    end

    if (lat_rise) begin
      col_cnt_d = {CNT_W{1'b0}};
      overrun_d = 1'b0;
      if ((cnt_after == CNT_W'(COLS)) && !over_after) begin
        if (s_addr == last_row_q) begin
          new_plane = next_plane(plane_q);
        end else begin
          new_plane = PLANE_W'(PLANES - 1);
        end
        // Plane and row history advance even when the line is dropped.
        plane_d    = new_plane;
        last_row_d = s_addr;
        if ((state_q == IDLE) && !commit_q) begin
          swap         = 1'b1;
          commit_d     = 1'b1;
          line_row_d   = s_addr;
          line_plane_d = new_plane;
        end else begin
          line_drop_d = 1'b1;
        end
      end else begin
        col_err_d = 1'b1;
      end
    end else begin
      col_cnt_d = cnt_after;
      overrun_d = over_after;
    end
  end

  // Fill side registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      col_cnt_q    <= {CNT_W{1'b0}};
      overrun_q    <= 1'b0;
      last_row_q   <= {ROW_BITS{1'b0}};
      plane_q      <= PLANE_W'(PLANES - 1);
      line_row_q   <= {ROW_BITS{1'b0}};
      line_plane_q <= {PLANE_W{1'b0}};
      commit_q     <= 1'b0;
      col_err_q    <= 1'b0;
      line_drop_q  <= 1'b0;
    end else begin
      col_cnt_q    <= col_cnt_d;
      overrun_q    <= overrun_d;
      last_row_q   <= last_row_d;
      plane_q      <= plane_d;
      line_row_q   <= line_row_d;
      line_plane_q <= line_plane_d;
      commit_q     <= commit_d;
      col_err_q    <= col_err_d;
      line_drop_q  <= line_drop_d;
    end
  end

  matrix_line_buffer u_buf (
    .clk     (clk_in),
    .rst_n   (reset),
    .wr_en   (wr_en),
    .wr_addr (col_cnt_q[COL_W-1:0]),
    .wr_data (s_rgb),
    .swap    (swap),
    .rd_addr (rd_addr),
    .rd_data (rd_data)
  );

  // ---------------- drain side ----------------
  // Read address is the column that will be presented after the next edge.
  always_comb begin
    if (state_q == IDLE) begin
      rd_addr = {COL_W{1'b0}};
    end else begin
      rd_addr = beat_q.col + COL_W'(1);
    end
  end

  // Drain FSM with registered beat outputs; beat holds while not accepted.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      beat_q  <= '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (commit_q) begin
            state_q      <= DRAIN;
            beat_q.row   <= line_row_q;
            beat_q.col   <= {COL_W{1'b0}};
            beat_q.plane <= line_plane_q;
            beat_q.rgb   <= rd_data;
            beat_q.first <= (line_row_q == {ROW_BITS{1'b0}}) &&
                            (line_plane_q == PLANE_W'(PLANES - 1));
          end
        end
        DRAIN: begin
          if (px_ready) begin
            if (beat_q.col == COL_W'(COLS - 1)) begin
              state_q      <= IDLE;
              beat_q.first <= 1'b0;
            end else begin
              beat_q.col   <= beat_q.col + COL_W'(1);
              beat_q.rgb   <= rd_data;
              beat_q.first <= 1'b0;
            end
          end
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign px_valid  = (state_q == DRAIN);
  assign px_row    = beat_q.row;
  assign px_col    = beat_q.col;
  assign px_plane  = beat_q.plane;
  assign px_rgb    = beat_q.rgb;
  assign px_first  = beat_q.first;
  assign col_err   = col_err_q;
  assign line_drop = line_drop_q;

`ifdef OE_MEASURE_EN
  logic [7:0] oe_cnt_q, oe_cnt_d;
  logic [7:0] oe_width_q, oe_width_d;
  logic       oe_armed_q, oe_armed_d;
  logic       oe_valid_q, oe_valid_d;
  logic       oe_fall;

  assign oe_fall = ~s_oe & prev_q[2];

  // OE high-time counter: armed by a latch, saturating, reported on OE fall.
  always_comb begin
    oe_cnt_d   = oe_cnt_q;
    oe_width_d = oe_width_q;
    oe_armed_d = oe_armed_q;
    oe_valid_d = 1'b0;
    if (lat_rise) begin
      oe_armed_d = 1'b1;
      oe_cnt_d   = 8'd0;
    end else if (oe_armed_q && s_oe) begin
      if (oe_cnt_q == 8'd255) begin
        oe_cnt_d = oe_cnt_q;
      end else begin
        oe_cnt_d = oe_cnt_q + 8'd1;
      end
    end else if (oe_armed_q && oe_fall) begin
      oe_width_d = oe_cnt_q;
      oe_valid_d = 1'b1;
      oe_armed_d = 1'b0;
    end else begin
      oe_cnt_d = oe_cnt_q;
    end
  end

  // OE measurement registers.
  always_ff @(posedge clk_in or negedge reset) begin
    if (!reset) begin
      oe_cnt_q   <= 8'd0;
      oe_width_q <= 8'd0;
      oe_armed_q <= 1'b0;
      oe_valid_q <= 1'b0;
    end else begin
      oe_cnt_q   <= oe_cnt_d;
      oe_width_q <= oe_width_d;
      oe_armed_q <= oe_armed_d;
      oe_valid_q <= oe_valid_d;
    end
  end

  assign oe_width = oe_width_q;
  assign oe_valid = oe_valid_q;
`else
  logic oe_unused;
  assign oe_unused = s_oe ^ prev_q[2];
  assign oe_width  = 8'd0;
  assign oe_valid  = 1'b0;
`endif

endmodule
